// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue/retire controller.
// Operand extension lives here so every consumer agrees on the 33-bit format.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  localparam int DIV_WIDTH       = 33;
  localparam int XLEN            = 32;
  localparam int OP_UNSIGNED_BIT = 0;
  localparam int OP_REM_BIT      = 1;

  // Bit 32 carries the sign for signed ops and is forced to 0 for unsigned ops.
  function automatic logic [DIV_WIDTH-1:0] extend_operand(input logic [XLEN-1:0] v,
                                                          input logic            is_unsigned);
    return {~is_unsigned & v[XLEN-1], v};
  endfunction

endpackage

// File: rtl/div_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module div_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, do_push, do_pop;

  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (count_o == (AW+1)'(DEPTH));
  assign do_pop   = pop_i & ~empty;
  // A simultaneous pop frees the slot being written when full.
  assign do_push  = push_i & (~full | do_pop);
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign valid_o = ~empty;
  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop_i));

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire wrapper around an external tag-less pipelined 33-bit divider:
// operand extension, in-flight tracking, quotient/remainder select, credit-guarded result FIFO.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 12,
  parameter int TAG_W       = 5,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [XLEN-1:0]      req_a,
  input  logic [XLEN-1:0]      req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [TAG_W-1:0]     resp_tag,
  output logic [DIV_WIDTH-1:0] div_numer,
  output logic [DIV_WIDTH-1:0] div_denom,
  input  logic [DIV_WIDTH-1:0] div_quotient,
  input  logic [DIV_WIDTH-1:0] div_remain
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int ENT_W = XLEN + TAG_W;

  logic                 accept, trk_exit, pop;
  logic [DIV_WIDTH-1:0] numer_q, numer_d, denom_q, denom_d;
  logic [DIV_LATENCY:0] trk_vld_q, trk_rem_q;
  logic [TAG_W-1:0]     trk_tag_q [DIV_LATENCY+1];
  logic [CRD_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENT_W-1:0]     fifo_wdata, fifo_rdata;
  logic [XLEN-1:0]      result;
  logic                 unused_msb;

  // Credits depend on state only, never on req_valid.
  assign req_ready = (CRD_W'(fifo_count) + inflight_q) < CRD_W'(FIFO_DEPTH);
  assign accept    = req_valid & req_ready;

  always_comb begin
    numer_d = '0;
    denom_d = '0;
    if (accept) begin
      numer_d = extend_operand(req_a, req_op[OP_UNSIGNED_BIT]);
      denom_d = extend_operand(req_b, req_op[OP_UNSIGNED_BIT]);
    end
  end

  // Input stage: zero when idle so garbage operands never reach the divider.
  always_ff @(posedge clock) begin
    if (reset) begin
      numer_q <= '0;
      denom_q <= '0;
    end else begin
      numer_q <= numer_d;
      denom_q <= denom_d;
    end
  end

  assign div_numer = numer_q;
  assign div_denom = denom_q;

  // Tracker: stage DIV_LATENCY lines up with the divider output for that request.
  always_ff @(posedge clock) begin
    if (reset) begin
      trk_vld_q  <= '0;
      inflight_q <= '0;
    end else begin
      trk_vld_q  <= {trk_vld_q[DIV_LATENCY-1:0], accept};
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clock) begin
    trk_rem_q    <= {trk_rem_q[DIV_LATENCY-1:0], accept & req_op[OP_REM_BIT]};
    trk_tag_q[0] <= accept ? req_tag : '0;
    for (int i = 1; i <= DIV_LATENCY; i++) trk_tag_q[i] <= trk_tag_q[i-1];
  end

  assign trk_exit   = trk_vld_q[DIV_LATENCY];
  assign inflight_d = inflight_q + CRD_W'(accept) - CRD_W'(trk_exit);

  // Result select and FIFO write.
  assign result     = trk_rem_q[DIV_LATENCY] ? div_remain[XLEN-1:0] : div_quotient[XLEN-1:0];
  assign fifo_wdata = {result, trk_tag_q[DIV_LATENCY]};
  assign pop        = resp_valid & resp_ready;
  assign unused_msb = div_quotient[DIV_WIDTH-1] ^ div_remain[DIV_WIDTH-1];

  div_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (trk_exit),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (resp_valid),
    .count_o (fifo_count)
  );

  assign resp_data = fifo_rdata[ENT_W-1:TAG_W];
  assign resp_tag  = fifo_rdata[TAG_W-1:0];

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Front-end and back-end for the 12-cycle pipelined 33-bit divider.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU requests over a valid/ready handshake and extends the 32-bit operands to 33 bits.
- Tracks in-flight operations alongside the tag-less divider pipeline, selects quotient or remainder, and buffers results in a credit-guarded FIFO so the divider never needs back-pressure.

Parameters:
- DIV_LATENCY, 12, divider latency in cycles; must equal the divider instance's LATENCY.
- TAG_W, 5, width of the opaque request tag (e.g. destination register or warp id).
- FIFO_DEPTH, 16, result FIFO entries; power of two, >= DIV_LATENCY+1 for full throughput.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready at rising edge
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_tag  in  TAG_W  returned unchanged with result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result when valid&&ready
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of result
- div_numer  out  33  to divider numer
- div_denom  out  33  to divider denom
- div_quotient  in  33  from divider
- div_remain  in  33  from divider

Behaviour:
- Extension: op[0]=0 (signed) sign-extends bit 31 to bit 32; op[0]=1 zero-extends.
- Divider corner cases pass through unmodified:
  - divide-by-zero gives quotient all-ones and remainder = dividend;
  - signed 0x80000000 / 0xFFFFFFFF gives 0x80000000, remainder 0;
  - unsigned operands never hit the overflow case because of zero-extension.
- Input stage: div_numer/div_denom are registered; loaded with the extended operands on accept, and with 0 otherwise.
- Tracker: shift register of {valid, is_rem, tag} with total delay DIV_LATENCY+1 from the accept edge, aligned so an entry exits exactly when the divider output holds its result.
- Result select: is_rem ? div_remain[31:0] : div_quotient[31:0].
- Latency: a request accepted at edge N is written to the FIFO at edge N+DIV_LATENCY+1. With an empty FIFO, resp_valid is high in the cycle after that edge.
- Throughput: one request per cycle.
- Credits:
  - inflight = number of tracker entries with valid set;
  - req_ready = (fifo_count + inflight < FIFO_DEPTH);
  - req_ready is registered-safe: it is computed from state only and does not depend on req_valid.
- Since the divider cannot stall, the credit check guarantees the FIFO never overflows. FIFO push while full is an assertion failure.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: allowed; count is unchanged.
  - Accept and tracker exit in the same cycle: inflight is unchanged.
  - A pop in cycle C frees a credit visible to req_ready in cycle C+1.
- FIFO: first-word-fall-through. resp_data/resp_tag are valid whenever resp_valid; results are returned in request order. Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Reset values (after the reset edge):
  - req_ready=1, resp_valid=0, resp_data=0, resp_tag=0;
  - div_numer=0, div_denom=0;
  - tracker valid bits=0, FIFO pointers=0, inflight=0.
- Reset mid-operation: all in-flight and buffered results are discarded. The divider has no reset; its stale outputs are ignored because the tracker valid bits are cleared.
- Unknown/X operands with req_valid=0 must not propagate to resp_* (the input stage loads 0).

Decomposition:
- Shared package: DivOp enum (DIV, DIVU, REM, REMU), DIV_WIDTH=33, XLEN=32, helper constant OP_UNSIGNED_BIT=0, OP_REM_BIT=1.
- Sub-module div_result_fifo: parameterised FWFT FIFO (width 32+TAG_W, depth FIFO_DEPTH, count output).
- The divider itself is instantiated by the parent, keeping the simulation and vendor dividers swappable.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2, tag=3, resp_ready=1 -> exactly DIV_LATENCY+2 cycles after accept cycle: resp_data=0xFFFFFFFD (-3), resp_tag=3; REM same operands -> 0xFFFFFFFF.
- DIVU a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC; REMU -> 1; checks zero-extension.
- Corner cases:
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0;
  - DIVU/DIV b=0, a=0x1234 -> 0xFFFFFFFF; REM/REMU -> 0x1234.
- Back-pressure: resp_ready=0, stream 20 back-to-back requests -> exactly FIFO_DEPTH (16) accepted and req_ready stays 0. Then raise resp_ready -> 20 results in order with correct tags, no loss/duplication; req_ready returns the cycle after the first pop.
- Reset with 5 requests in flight and 3 buffered -> no resp_valid until a new request; the next request (DIV 100/7) returns 14 with its own tag only.
- Random regression: 10k random ops/operands/resp_ready against a reference model -> zero mismatches, order preserved.
